// File: rtl/router_pkg.sv
// Shared constants for the router datapath: byte width, per-channel buffer depth
// and the layout of the header byte.
package router_pkg;

    localparam int DATA_W      = 8;
    localparam int FIFO_DEPTH  = 16;
    localparam int HDR_LEN_MSB = 7;
    localparam int HDR_LEN_LSB = 2;
    localparam int TAG_BIT     = DATA_W;
    localparam int PKT_CNT_W   = HDR_LEN_MSB - HDR_LEN_LSB + 1;

    typedef logic [PKT_CNT_W-1:0] pkt_cnt_t;

endpackage

// File: rtl/router_fifo_if.sv
// Write/read handshake between the synchronizer, the egress consumer and one
// per-channel packet buffer.
interface router_fifo_if
    import router_pkg::*;
#(
    parameter int WIDTH = DATA_W
);

    logic             soft_reset;
    logic             write_enb;
    logic             read_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;

    modport master (
        output soft_reset, write_enb, read_enb, lfd_state, data_in,
        input  data_out, full, empty
    );

    modport slave (
        input  soft_reset, write_enb, read_enb, lfd_state, data_in,
        output data_out, full, empty
    );

endinterface

// File: rtl/router_fifo.sv
// Per-destination packet buffer: tags header bytes on write and tracks the
// remaining packet length on read so data_out idles at zero between packets.
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = DATA_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         resetn,
    router_fifo_if.slave fifo
);

    logic [WIDTH:0]   r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_data_out;
    pkt_cnt_t         r_pkt_cnt;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_ok;
    logic             w_rd_ok;
    logic [WIDTH:0]   w_rd_entry;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr_ok    = fifo.write_enb && !w_full;
    assign w_rd_ok    = fifo.read_enb && !w_empty;
    assign w_rd_entry = r_mem[r_rd_ptr[AW-1:0]];

    // Storage is never cleared; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (resetn && !fifo.soft_reset && w_wr_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {fifo.lfd_state, fifo.data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || fifo.soft_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pkt_cnt  <= '0;
            r_data_out <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_data_out <= w_rd_entry[WIDTH-1:0];
                // Header reload counts the payload plus the trailing parity byte.
                if (w_rd_entry[TAG_BIT]) begin
                    r_pkt_cnt <= w_rd_entry[HDR_LEN_MSB:HDR_LEN_LSB] + PKT_CNT_W'(1);
                end else if (r_pkt_cnt != '0) begin
                    r_pkt_cnt <= r_pkt_cnt - PKT_CNT_W'(1);
                end
            end else if (r_pkt_cnt == '0) begin
                r_data_out <= '0;
            end
        end
    end

    assign fifo.data_out = r_data_out;
    assign fifo.full     = w_full;
    assign fifo.empty    = w_empty;

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: queue model plus read scoreboard, a vector
// table for the basic packet and hand-written corner-case sequences.
module tb_router_fifo;
    import router_pkg::*;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    router_fifo_if #(.WIDTH(8)) bus ();

    router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .fifo   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [8:0] m_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_dout = 8'h00;
    logic [5:0] m_pkt  = 6'd0;

    typedef struct {
        logic       wen;
        logic       ren;
        logic       lfd;
        logic [7:0] din;
        logic [7:0] exp_dout;
        logic       exp_empty;
        logic       exp_full;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance, update the model, compare outputs.
    task automatic cycle(input logic rn, input logic srst, input logic wen,
                         input logic ren, input logic lfd, input logic [7:0] din);
        bit         pre_full;
        bit         pre_empty;
        bit         rd_acc;
        logic [8:0] e;
        logic [7:0] exp_b;
        pre_full  = (m_q.size() == 16);
        pre_empty = (m_q.size() == 0);
        rd_acc    = 1'b0;
        resetn          = rn;
        bus.soft_reset  = srst;
        bus.write_enb   = wen;
        bus.read_enb    = ren;
        bus.lfd_state   = lfd;
        bus.data_in     = din;
        @(posedge clk);
        #1;
        if (!rn || srst) begin
            m_q.delete();
            exp_q.delete();
            m_dout = 8'h00;
            m_pkt  = 6'd0;
        end else begin
            if (ren && !pre_empty) begin
                e = m_q.pop_front();
                exp_q.push_back(e[7:0]);
                rd_acc = 1'b1;
                if (e[8]) m_pkt = e[7:2] + 6'd1;
                else if (m_pkt != 6'd0) m_pkt = m_pkt - 6'd1;
                m_dout = e[7:0];
            end else if (m_pkt == 6'd0) begin
                m_dout = 8'h00;
            end
            if (wen && !pre_full) m_q.push_back({lfd, din});
        end
        if (rd_acc) begin
            exp_b = exp_q.pop_front();
            chk("read_data", {24'd0, bus.data_out}, {24'd0, exp_b});
        end else begin
            chk("idle_data", {24'd0, bus.data_out}, {24'd0, m_dout});
        end
        chk("empty", {31'd0, bus.empty}, {31'd0, (m_q.size() == 0)});
        chk("full",  {31'd0, bus.full},  {31'd0, (m_q.size() == 16)});
    endtask

    task automatic wr(input logic lfd, input logic [7:0] din);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, lfd, din);
    endtask

    task automatic rd();
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        bus.soft_reset = 1'b0;
        bus.write_enb  = 1'b0;
        bus.read_enb   = 1'b0;
        bus.lfd_state  = 1'b0;
        bus.data_in    = 8'h00;

        tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'h0C, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h33, 8'h00, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h44, 8'h00, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h0C, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h11, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h22, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h33, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h44, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};

        // Reset state
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst_empty", {31'd0, bus.empty}, 32'd1);
        chk("rst_full",  {31'd0, bus.full},  32'd0);
        chk("rst_dout",  {24'd0, bus.data_out}, 32'd0);

        // Single packet from the vector table
        for (int i = 0; i < 11; i++) begin
            cycle(1'b1, 1'b0, tbl[i].wen, tbl[i].ren, tbl[i].lfd, tbl[i].din);
            chk("tbl_dout",  {24'd0, bus.data_out}, {24'd0, tbl[i].exp_dout});
            chk("tbl_empty", {31'd0, bus.empty},    {31'd0, tbl[i].exp_empty});
            chk("tbl_full",  {31'd0, bus.full},     {31'd0, tbl[i].exp_full});
        end

        // Fill to full, drop the 17th write, drain in order
        for (int i = 0; i < 16; i++) wr(1'b0, 8'hA0 + 8'(i));
        chk("t2_full", {31'd0, bus.full}, 32'd1);
        wr(1'b0, 8'h5A);
        for (int i = 0; i < 16; i++) begin
            rd();
            chk("t2_order", {24'd0, bus.data_out}, {24'd0, 8'hA0 + 8'(i)});
        end
        idle();

        // Simultaneous read and write while full
        for (int i = 0; i < 16; i++) wr(1'b0, 8'h30 + 8'(i));
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hEE);
        chk("t3_rw_dout", {24'd0, bus.data_out}, 32'h30);
        chk("t3_not_full", {31'd0, bus.full}, 32'd0);
        for (int i = 1; i < 16; i++) begin
            chk("t3_not_empty", {31'd0, bus.empty}, 32'd0);
            rd();
            chk("t3_order", {24'd0, bus.data_out}, {24'd0, 8'h30 + 8'(i)});
        end
        chk("t3_empty_after_15", {31'd0, bus.empty}, 32'd1);
        idle();

        // Flush mid-packet with a concurrent write
        wr(1'b1, 8'h20);
        for (int i = 1; i < 10; i++) wr(1'b0, 8'h60 + 8'(i));
        rd();
        idle();
        chk("t4_hold", {24'd0, bus.data_out}, 32'h20);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hBB);
        chk("t4_empty", {31'd0, bus.empty}, 32'd1);
        chk("t4_full",  {31'd0, bus.full},  32'd0);
        chk("t4_dout",  {24'd0, bus.data_out}, 32'd0);
        rd();
        chk("t4_no_data", {24'd0, bus.data_out}, 32'd0);

        // Pointer wrap with write-then-read pairs
        for (int i = 0; i < 40; i++) begin
            wr(1'b0, 8'(i * 7 + 3));
            rd();
            chk("t5_data", {24'd0, bus.data_out}, {24'd0, 8'(i * 7 + 3)});
        end
        idle();

        // Hard reset mid-packet, then a fresh packet with a read gap
        wr(1'b1, 8'h08);
        wr(1'b0, 8'h71);
        wr(1'b0, 8'h72);
        wr(1'b0, 8'h73);
        rd();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("t6_rst_dout",  {24'd0, bus.data_out}, 32'd0);
        chk("t6_rst_empty", {31'd0, bus.empty}, 32'd1);
        wr(1'b1, 8'h10);
        for (int i = 1; i <= 5; i++) wr(1'b0, 8'h80 + 8'(i));
        rd();
        idle();
        chk("t6_hold_hdr", {24'd0, bus.data_out}, 32'h10);
        for (int i = 1; i <= 5; i++) rd();
        chk("t6_last", {24'd0, bus.data_out}, 32'h85);
        idle();
        chk("t6_zero", {24'd0, bus.data_out}, 32'd0);
        chk("t6_empty", {31'd0, bus.empty}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- Per-destination packet buffer between the router's write-side control/synchronizer and the egress read port; three instances, one per output channel.
- Accepts bytes when its write_enb bit is asserted and tags the header byte using lfd_state.
- Reports full/empty back to the synchronizer and flushes on soft_reset (read-timeout).
- Tracks remaining packet length on the read side so data_out returns to 0 between packets.

Parameters:
- DEPTH, 16, number of entries; must be a power of 2.
- WIDTH, 8, data byte width.
- AW, $clog2(DEPTH), address width. Pointers are AW+1 bits wide.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  synchronous active-low reset
- soft_reset  in  1  synchronous flush from synchronizer timeout, active high
- write_enb  in  1  write request (one bit of the synchronizer's write_enb)
- read_enb  in  1  read request from the egress consumer
- lfd_state  in  1  high while the current write byte is a packet header
- data_in  in  WIDTH  byte to store
- data_out  out  WIDTH  registered read data
- full  out  1  no free entries
- empty  out  1  no stored entries

Behaviour:
- Clock, reset: one clock (clk). Reset is synchronous, active-low (resetn). Every state change happens on the rising edge of clk.
- Storage: DEPTH entries of WIDTH+1 bits; bit WIDTH is the header tag (= lfd_state at write). Memory contents are not cleared on reset or flush.
- Pointers: wr_ptr and rd_ptr, each AW+1 bits, including a wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and the low AW bits are equal.
  - Both flags are combinational from the registered pointers.
- Write: accepted iff write_enb && !full. The entry is written at wr_ptr[AW-1:0], then wr_ptr increments. A write while full is dropped with no state change.
- Read: accepted iff read_enb && !empty. data_out <= entry[WIDTH-1:0] on the next edge (1-cycle latency), then rd_ptr increments. A read while empty is ignored.
- Simultaneous read and write:
  - Both proceed independently, gated by their own flags.
  - When full, the read succeeds and the write is still dropped that cycle (full evaluated before the edge).
  - When empty, the write succeeds and the read is ignored.
- Packet counter pkt_cnt (6 bits):
  - On an accepted read of a tagged entry: pkt_cnt <= entry[7:2] + 1 (payload length plus parity byte).
  - On an accepted read of an untagged entry with pkt_cnt != 0: pkt_cnt decrements.
  - When no read is accepted and pkt_cnt == 0: data_out <= 0.
  - When no read is accepted and pkt_cnt != 0: data_out holds its value.
- Reset (resetn == 0): wr_ptr, rd_ptr, pkt_cnt and data_out go to 0. Result: empty = 1, full = 0, data_out = 0.
- soft_reset == 1 (with resetn == 1):
  - Same effect as reset, and it takes priority over any read or write in that cycle.
  - A flush mid-packet discards the remaining bytes. The next header write starts cleanly.
- Wrap-around: pointers wrap modulo 2*DEPTH. No special casing is needed.

Decomposition:
- Shared package router_pkg holds:
  - DATA_W = 8
  - FIFO_DEPTH = 16
  - HDR_LEN_MSB = 7, HDR_LEN_LSB = 2 (payload-length field in the header)
  - the tag-bit index
- No sub-module; the memory array is inferred inside router_fifo.

Test Plan:
1. Reset, then write header 8'h0C (lfd=1, length 3) and payload 11,22,33, parity 44; read 5 times → data_out sequence 0C,11,22,33,44, one cycle after each read_enb; data_out = 0 the cycle after the last read; empty = 1.
2. Write 16 bytes with no reads → full = 1 after the 16th; a 17th write is dropped; the next 16 reads return the original 16 bytes in order.
3. While full, assert read_enb and write_enb together → one byte leaves, the new byte is not stored; the next cycle full = 0; count = 15.
4. Fill 10 bytes, pulse soft_reset together with write_enb → empty = 1, full = 0, data_out = 0 next cycle; the concurrent write is discarded.
5. Pointer wrap: repeat 40 single write-then-read pairs → data integrity is preserved; empty toggles correctly across the wrap of the 5-bit pointers.
6. Assert resetn = 0 mid-packet (pkt_cnt = 3) → all outputs reset; a subsequent read of a newly written header reloads pkt_cnt correctly.
